// File: rtl/trap_seq_if.sv
// Request, redirect handshake and status bundle between the CSR/exception
// unit, the trap sequencer and fetch.
interface trap_seq_if;
    logic        initiate_illinst;
    logic        initiate_misaligned;
    logic        mret;
    logic [31:0] csr_mepc;
    logic        redirect_ready;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [7:0]  trap_count;

    modport master (
        input  initiate_illinst, initiate_misaligned, mret, csr_mepc,
        input  redirect_ready,
        output flush, redirect_valid, redirect_pc, busy, trap_count
    );

    modport slave (
        output initiate_illinst, initiate_misaligned, mret, csr_mepc,
        output redirect_ready,
        input  flush, redirect_valid, redirect_pc, busy, trap_count
    );
endinterface

// File: rtl/trap_sequencer.sv
// Flush-then-redirect sequencer for traps and MRET, with saturating trap count.
// Define TRAP_SEQ_MRET_EN to make mret a request source (target csr_mepc).
module trap_sequencer #(
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    trap_seq_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        rv_q, rv_d;
    logic        busy_q, busy_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  tc_q, tc_d;
    logic        trap_req;
    logic        mret_req;

    assign trap_req = bus.initiate_illinst | bus.initiate_misaligned;

`ifdef TRAP_SEQ_MRET_EN
    assign mret_req = bus.mret;
`else
    // MRET is raised as illegal instruction by decode in this build.
    logic unused_mret;
    assign unused_mret = bus.mret;
    assign mret_req    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        rv_d    = rv_q;
        pc_d    = pc_q;
        tc_d    = tc_q;
        unique case (state_q)
            IDLE: begin
                if (trap_req || mret_req) begin
                    pc_d = trap_req ? TRAP_VECTOR : bus.csr_mepc;
                    if (trap_req && tc_q != 8'hFF) begin
                        tc_d = tc_q + 8'd1;
                    end
                    if (FLUSH_CYCLES == 0) begin
                        state_d = REDIRECT;
                        rv_d    = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        flush_d = 1'b1;
                        cnt_d   = 4'(FLUSH_CYCLES);
                    end
                end
            end
            DRAIN: begin
                if (cnt_q <= 4'd1) begin
                    state_d = REDIRECT;
                    flush_d = 1'b0;
                    rv_d    = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_d = IDLE;
                    rv_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = 1'b0;
                rv_d    = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            flush_q <= 1'b0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
            pc_q    <= 32'h0;
            tc_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            rv_q    <= rv_d;
            busy_q  <= busy_d;
            pc_q    <= pc_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.flush          = flush_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.busy           = busy_q;
    assign bus.trap_count     = tc_q;
endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: FLUSH_CYCLES=2 and FLUSH_CYCLES=0 instances
// checked with directed scenarios and random stimulus against a timing model.
module tb_trap_sequencer;
    localparam logic [31:0] TV1 = 32'h8000_0040;
`ifdef TRAP_SEQ_MRET_EN
    localparam bit MEN = 1'b1;
`else
    localparam bit MEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ill = 1'b0, mis = 1'b0, mr = 1'b0, rdy = 1'b0;
    logic [31:0] mepc = 32'h0;

    trap_seq_if if0 ();
    trap_seq_if if1 ();

    assign if0.initiate_illinst    = ill;
    assign if0.initiate_misaligned = mis;
    assign if0.mret                = mr;
    assign if0.csr_mepc            = mepc;
    assign if0.redirect_ready      = rdy;
    assign if1.initiate_illinst    = ill;
    assign if1.initiate_misaligned = mis;
    assign if1.mret                = mr;
    assign if1.csr_mepc            = mepc;
    assign if1.redirect_ready      = rdy;

    trap_sequencer #(.TRAP_VECTOR(32'h0), .FLUSH_CYCLES(2)) dut0 (
        .clk(clk), .reset(rst), .bus(if0));
    trap_sequencer #(.TRAP_VECTOR(TV1), .FLUSH_CYCLES(0)) dut1 (
        .clk(clk), .reset(rst), .bus(if1));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model: a sequence is a start cycle; outputs follow from cycle arithmetic.
    int          fl[2] = '{2, 0};
    logic [31:0] tv[2] = '{32'h0, TV1};
    bit          m_act[2];
    int          m_st[2];
    logic [31:0] m_pc[2];
    int          m_cnt[2];

    function automatic bit e_rv(int d);
        return m_act[d] && (cyc >= m_st[d] + fl[d] + 1);
    endfunction

    function automatic bit e_fl(int d);
        return m_act[d] && (cyc <= m_st[d] + fl[d]);
    endfunction

    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d] = 1'b0;
                m_pc[d]  = 32'h0;
                m_cnt[d] = 0;
            end else if (!m_act[d]) begin
                if (ill || mis || (MEN && mr)) begin
                    m_act[d] = 1'b1;
                    m_st[d]  = cyc;
                    m_pc[d]  = (ill || mis) ? tv[d] : mepc;
                    if ((ill || mis) && m_cnt[d] < 255) m_cnt[d]++;
                end
            end else if (e_rv(d) && rdy) begin
                m_act[d] = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_chk++;
        if ({if0.flush, if0.redirect_valid, if0.busy, if0.redirect_pc,
             if0.trap_count} !== 43'h0) begin
            n_fail++;
            $display("FAIL reset0 got f=%b v=%b b=%b pc=%h c=%h exp all 0",
                     if0.flush, if0.redirect_valid, if0.busy,
                     if0.redirect_pc, if0.trap_count);
        end
        n_chk++;
        if ({if1.flush, if1.redirect_valid, if1.busy, if1.redirect_pc,
             if1.trap_count} !== 43'h0) begin
            n_fail++;
            $display("FAIL reset1 got f=%b v=%b b=%b pc=%h c=%h exp all 0",
                     if1.flush, if1.redirect_valid, if1.busy,
                     if1.redirect_pc, if1.trap_count);
        end
    endtask

    task automatic test_trap_default();
        ill = 1'b1;
        rdy = 1'b1;
        tick();
        ill = 1'b0;
        n_chk++;
        if ({if0.flush, if0.redirect_valid, if0.busy, if0.trap_count}
            !== {3'b101, 8'd1}) begin
            n_fail++;
            $display("FAIL trap_n1 got fvb=%b%b%b c=%0d exp fvb=101 c=1",
                     if0.flush, if0.redirect_valid, if0.busy, if0.trap_count);
        end
        n_chk++;
        if ({if1.flush, if1.redirect_valid, if1.busy, if1.redirect_pc}
            !== {3'b011, TV1}) begin
            n_fail++;
            $display("FAIL trap_nf_n1 got fvb=%b%b%b pc=%h exp fvb=011 pc=%h",
                     if1.flush, if1.redirect_valid, if1.busy,
                     if1.redirect_pc, TV1);
        end
        tick();
        n_chk++;
        if ({if0.flush, if0.redirect_valid, if0.busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL trap_n2 got fvb=%b%b%b exp 101",
                     if0.flush, if0.redirect_valid, if0.busy);
        end
        n_chk++;
        if ({if1.redirect_valid, if1.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL trap_nf_n2 got vb=%b%b exp 00",
                     if1.redirect_valid, if1.busy);
        end
        tick();
        n_chk++;
        if ({if0.flush, if0.redirect_valid, if0.busy, if0.redirect_pc}
            !== {3'b011, 32'h0}) begin
            n_fail++;
            $display("FAIL trap_n3 got fvb=%b%b%b pc=%h exp fvb=011 pc=0",
                     if0.flush, if0.redirect_valid, if0.busy, if0.redirect_pc);
        end
        tick();
        n_chk++;
        if ({if0.redirect_valid, if0.busy, if0.trap_count}
            !== {2'b00, 8'd1}) begin
            n_fail++;
            $display("FAIL trap_n4 got vb=%b%b c=%0d exp vb=00 c=1",
                     if0.redirect_valid, if0.busy, if0.trap_count);
        end
        rdy = 1'b0;
    endtask

    task automatic test_mret_target();
        logic [42:0] exp0, exp1;
        mr   = 1'b1;
        mepc = 32'h0000_0124;
        rdy  = 1'b0;
        tick();
        mr   = 1'b0;
        mepc = 32'hDEAD_BEEF;
        for (int k = 1; k <= 5; k++) begin
            exp0 = MEN ? {(k <= 2), (k >= 3), 1'b1, 32'h124, 8'd1}
                       : {3'b000, 32'h0, 8'd1};
            exp1 = MEN ? {3'b011, 32'h124, 8'd1}
                       : {3'b000, TV1, 8'd1};
            n_chk++;
            if ({if0.flush, if0.redirect_valid, if0.busy, if0.redirect_pc,
                 if0.trap_count} !== exp0) begin
                n_fail++;
                $display("FAIL mret0 k=%0d got %h exp %h", k,
                         {if0.flush, if0.redirect_valid, if0.busy,
                          if0.redirect_pc, if0.trap_count}, exp0);
            end
            n_chk++;
            if ({if1.flush, if1.redirect_valid, if1.busy, if1.redirect_pc,
                 if1.trap_count} !== exp1) begin
                n_fail++;
                $display("FAIL mret1 k=%0d got %h exp %h", k,
                         {if1.flush, if1.redirect_valid, if1.busy,
                          if1.redirect_pc, if1.trap_count}, exp1);
            end
            tick();
        end
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        n_chk++;
        if ({if0.busy, if1.busy, if0.redirect_valid, if1.redirect_valid}
            !== 4'b0000) begin
            n_fail++;
            $display("FAIL mret_done got b=%b%b v=%b%b exp 0000",
                     if0.busy, if1.busy, if0.redirect_valid,
                     if1.redirect_valid);
        end
    endtask

    task automatic test_simultaneous();
        int c0, c1;
        c0   = m_cnt[0];
        c1   = m_cnt[1];
        ill  = 1'b1;
        mis  = 1'b1;
        mr   = 1'b1;
        mepc = 32'h0000_0055;
        rdy  = 1'b1;
        tick();
        ill = 1'b0;
        mis = 1'b0;
        mr  = 1'b0;
        n_chk++;
        if ({if1.redirect_valid, if1.redirect_pc, if1.trap_count}
            !== {1'b1, TV1, 8'(c1 + 1)}) begin
            n_fail++;
            $display("FAIL simul1 got v=%b pc=%h c=%0d exp v=1 pc=%h c=%0d",
                     if1.redirect_valid, if1.redirect_pc, if1.trap_count,
                     TV1, c1 + 1);
        end
        n_chk++;
        if (if0.trap_count !== 8'(c0 + 1)) begin
            n_fail++;
            $display("FAIL simul0_cnt got %0d exp %0d", if0.trap_count, c0 + 1);
        end
        tick();
        tick();
        n_chk++;
        if ({if0.redirect_valid, if0.redirect_pc} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL simul0_pc got v=%b pc=%h exp v=1 pc=0",
                     if0.redirect_valid, if0.redirect_pc);
        end
        tick();
        rdy = 1'b0;
    endtask

    task automatic test_busy_reject();
        int c0, c1, hs0, hs1;
        c0  = m_cnt[0];
        c1  = m_cnt[1];
        hs0 = 0;
        hs1 = 0;
        ill = 1'b1;
        rdy = 1'b0;
        tick();
        ill = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            mis = (k == 1 || k == 3);
            rdy = (k == 4);
            if (if0.redirect_valid && rdy) hs0++;
            if (if1.redirect_valid && rdy) hs1++;
            tick();
        end
        mis = 1'b0;
        rdy = 1'b0;
        n_chk++;
        if (hs0 != 1 || hs1 != 1) begin
            n_fail++;
            $display("FAIL busy_redirects got %0d/%0d exp 1/1", hs0, hs1);
        end
        n_chk++;
        if ({if0.trap_count, if1.trap_count, if0.busy, if1.busy}
            !== {8'(c0 + 1), 8'(c1 + 1), 2'b00}) begin
            n_fail++;
            $display("FAIL busy_cnt got %0d/%0d b=%b%b exp %0d/%0d b=00",
                     if0.trap_count, if1.trap_count, if0.busy, if1.busy,
                     c0 + 1, c1 + 1);
        end
    endtask

    task automatic test_saturation();
        rdy = 1'b1;
        for (int i = 0; i < 260; i++) begin
            ill = 1'b1;
            tick();
            ill = 1'b0;
            n_chk++;
            if (if1.redirect_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_rv i=%0d got %b exp 1", i, if1.redirect_valid);
            end
            tick();
        end
        n_chk++;
        if (if1.trap_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL sat_cnt1 got %h exp ff", if1.trap_count);
        end
        n_chk++;
        if (if0.trap_count !== 8'(m_cnt[0])) begin
            n_fail++;
            $display("FAIL sat_cnt0 got %0d exp %0d", if0.trap_count, m_cnt[0]);
        end
        repeat (4) tick();
        rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        ill = 1'b1;
        tick();
        ill = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({if0.flush, if0.redirect_valid, if0.busy, if0.redirect_pc,
             if0.trap_count, if1.redirect_valid, if1.busy, if1.trap_count}
            !== 53'h0) begin
            n_fail++;
            $display("FAIL reset_mid got f=%b v=%b b=%b pc=%h c=%h v1=%b b1=%b c1=%h exp all 0",
                     if0.flush, if0.redirect_valid, if0.busy, if0.redirect_pc,
                     if0.trap_count, if1.redirect_valid, if1.busy,
                     if1.trap_count);
        end
    endtask

    task automatic test_mret_gate();
        mr   = 1'b1;
        mepc = 32'h0000_0200;
        rdy  = 1'b0;
        tick();
        mr = 1'b0;
        n_chk++;
        if ({if0.busy, if1.busy} !== {MEN, MEN}) begin
            n_fail++;
            $display("FAIL mret_gate got b=%b%b exp %b%b",
                     if0.busy, if1.busy, MEN, MEN);
        end
        rdy = 1'b1;
        repeat (4) tick();
        rdy = 1'b0;
    endtask

    task automatic test_random();
        logic [42:0] e0, e1;
        for (int i = 0; i < 600; i++) begin
            e0 = {e_fl(0), e_rv(0), m_act[0], m_pc[0], 8'(m_cnt[0])};
            e1 = {e_fl(1), e_rv(1), m_act[1], m_pc[1], 8'(m_cnt[1])};
            n_chk++;
            if ({if0.flush, if0.redirect_valid, if0.busy, if0.redirect_pc,
                 if0.trap_count} !== e0) begin
                n_fail++;
                $display("FAIL rand0 cyc=%0d got %h exp %h", cyc,
                         {if0.flush, if0.redirect_valid, if0.busy,
                          if0.redirect_pc, if0.trap_count}, e0);
            end
            n_chk++;
            if ({if1.flush, if1.redirect_valid, if1.busy, if1.redirect_pc,
                 if1.trap_count} !== e1) begin
                n_fail++;
                $display("FAIL rand1 cyc=%0d got %h exp %h", cyc,
                         {if1.flush, if1.redirect_valid, if1.busy,
                          if1.redirect_pc, if1.trap_count}, e1);
            end
            ill  = ($urandom % 8) == 0;
            mis  = ($urandom % 8) == 0;
            mr   = ($urandom % 5) == 0;
            mepc = $urandom;
            rdy  = ($urandom % 2) == 0;
            rst  = ($urandom % 97) == 0;
            tick();
        end
        ill = 1'b0;
        mis = 1'b0;
        mr  = 1'b0;
        rst = 1'b0;
        rdy = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_trap_default();
        test_mret_target();
        test_simultaneous();
        test_busy_reject();
        test_saturation();
        test_reset_mid();
        test_mret_gate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
